cache_block: RTL and testbench

// - Unified 16-bit data cache for the 5-stage MIPS pipeline, used in the MEM stage.
// - Direct-mapped, write-through, no-write-allocate.
// - Contains its own behavioural backing memory.
// - Raises StallPipeline while a read miss fills a line.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_main_memory.sv | 33 +++
 rtl/cache_block.sv | 127 ++++++++++++
 tb/tb_cache_block.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the direct-mapped data cache.
package cache_pkg;

  localparam int unsigned NumLines     = 16;
  localparam int unsigned WordsPerLine = 4;
  localparam int unsigned IW           = $clog2(NumLines);
  localparam int unsigned OW           = $clog2(WordsPerLine);
  localparam int unsigned TW           = 16 - OW - IW;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StFill
  } cacheState_e;

  function automatic logic [OW-1:0] getOffset(input logic [15:0] addr);
    return addr[OW-1:0];
  endfunction

  function automatic logic [IW-1:0] getIndex(input logic [15:0] addr);
    return addr[OW+IW-1:OW];
  endfunction

  function automatic logic [TW-1:0] getTag(input logic [15:0] addr);
    return addr[15:OW+IW];
  endfunction

endpackage

// File: rtl/cache_main_memory.sv
// Behavioural backing store: synchronous word write, combinational whole-line read.
module cache_main_memory #(
  parameter int unsigned MEM_AW         = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                                  clk,
  input  logic                                  writeEn,
  input  logic [MEM_AW-1:0]                     writeAddr,
  input  logic [15:0]                           writeData,
  input  logic [MEM_AW-$clog2(WORDS_PER_LINE)-1:0] lineAddr,
  output logic [WORDS_PER_LINE-1:0][15:0]       lineData
);

  localparam int unsigned OW    = $clog2(WORDS_PER_LINE);
  localparam int unsigned Depth = 1 << MEM_AW;

  // Contents start at zero and deliberately survive the cache reset.
  logic [15:0] mem [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  always_comb begin
    lineData = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      lineData[w] = mem[{lineAddr, OW'(w)}];
    end
  end

endmodule

// File: rtl/cache_block.sv
// Direct-mapped, write-through, no-write-allocate 16-bit data cache for the MEM stage.
// A read miss stalls the pipeline for MISS_LATENCY+1 cycles while the line is filled.
module cache_block
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned MEM_AW         = 16,
  parameter int unsigned MISS_LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] DataIn,
  input  logic        write,
  input  logic [15:0] MemAddress,
  output logic [15:0] DataOutMainModule,
  output logic        StallPipeline
);

  localparam int unsigned LIW = $clog2(NUM_LINES);
  localparam int unsigned LOW = $clog2(WORDS_PER_LINE);
  localparam int unsigned LTW = 16 - LOW - LIW;
  localparam int unsigned LAW = MEM_AW - LOW;
  localparam int unsigned CW  = $clog2(MISS_LATENCY + 1);

  logic [LOW-1:0] offset;
  logic [LIW-1:0] index;
  logic [LTW-1:0] tag;

  logic [NUM_LINES-1:0] validBits;
  logic [LTW-1:0]       tagStore  [NUM_LINES];
  logic [15:0]          dataStore [NUM_LINES][WORDS_PER_LINE];

  cacheState_e    state;
  logic [CW-1:0]  waitCnt;
  logic [CW-1:0]  waitNext;
  logic [LTW-1:0] reqTag;
  logic [LIW-1:0] reqIndex;
  logic [15-LOW:0] reqLine;

  logic                             hit;
  logic                             memWe;
  logic [LAW-1:0]                   lineAddr;
  logic [WORDS_PER_LINE-1:0][15:0]  lineData;

  assign offset   = MemAddress[LOW-1:0];
  assign index    = MemAddress[LOW+LIW-1:LOW];
  assign tag      = MemAddress[15:LOW+LIW];
  assign hit      = validBits[index] && (tagStore[index] == tag);
  assign memWe    = !rst && (state == StIdle) && write;
  assign reqLine  = {reqTag, reqIndex};
  assign lineAddr = reqLine[LAW-1:0];
  assign waitNext = waitCnt + 1'b1;

  cache_main_memory #(
    .MEM_AW         (MEM_AW),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) uMainMemory (
    .clk       (clk),
    .writeEn   (memWe),
    .writeAddr (MemAddress[MEM_AW-1:0]),
    .writeData (DataIn),
    .lineAddr  (lineAddr),
    .lineData  (lineData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      validBits <= '0;
      state     <= StIdle;
      waitCnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (write) begin
            if (hit) begin
              dataStore[index][offset] <= DataIn;
            end
          end else if (!hit) begin
            reqTag   <= tag;
            reqIndex <= index;
            waitCnt  <= '0;
            // With a one-cycle latency there is nothing to wait for.
            state    <= (MISS_LATENCY == 1) ? StFill : StWait;
          end
        end
        StWait: begin
          // The incremented count is compared so the total stall is MISS_LATENCY+1 cycles.
          waitCnt <= waitNext;
          if (waitNext == CW'(MISS_LATENCY - 1)) begin
            state <= StFill;
          end
        end
        StFill: begin
          for (int w = 0; w < WORDS_PER_LINE; w++) begin
            dataStore[reqIndex][w] <= lineData[w];
          end
          tagStore[reqIndex]  <= reqTag;
          validBits[reqIndex] <= 1'b1;
          state               <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    DataOutMainModule = '0;
    StallPipeline     = 1'b0;
    if (!rst) begin
      unique case (state)
        StIdle: begin
          if (!write) begin
            if (hit) begin
              DataOutMainModule = dataStore[index][offset];
            end else begin
              StallPipeline = 1'b1;
            end
          end
        end
        StWait, StFill: StallPipeline = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_block.sv
// Self-checking bench for cache_block: a reference memory/tag model feeds a scoreboard queue.
module tb_cache_block;
  import cache_pkg::*;

  localparam int MissLat  = 4;
  localparam int MissStall = MissLat + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DataIn;
  logic        write;
  logic [15:0] MemAddress;
  logic [15:0] DataOutMainModule;
  logic        StallPipeline;

  cache_block #(
    .NUM_LINES      (16),
    .WORDS_PER_LINE (4),
    .MEM_AW         (16),
    .MISS_LATENCY   (MissLat)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .DataIn            (DataIn),
    .write             (write),
    .MemAddress        (MemAddress),
    .DataOutMainModule (DataOutMainModule),
    .StallPipeline     (StallPipeline)
  );

  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [15:0]   mMem   [65536];
  logic          mValid [16];
  logic [TW-1:0] mTag   [16];
  logic [15:0]   expQ   [$];

  function automatic bit modelHit(input logic [15:0] a);
    return mValid[getIndex(a)] && (mTag[getIndex(a)] == getTag(a));
  endfunction

  function automatic int expStall(input logic [15:0] a);
    return modelHit(a) ? 0 : MissStall;
  endfunction

  task automatic modelFill(input logic [15:0] a);
    mValid[getIndex(a)] = 1'b1;
    mTag[getIndex(a)]   = getTag(a);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
  endtask

  // Drives one load and reports stall cycles and the data seen once the stall drops.
  task automatic run_load(input logic [15:0] a, output int stalls, output logic [15:0] d);
    write = 1'b0;
    MemAddress = a;
    stalls = 0;
    @(negedge clk);
    while (StallPipeline && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    d = DataOutMainModule;
    @(posedge clk);
    #1;
  endtask

  task automatic run_store(input logic [15:0] a, input logic [15:0] v,
                           output logic st, output logic [15:0] d);
    write = 1'b1;
    DataIn = v;
    MemAddress = a;
    @(negedge clk);
    st = StallPipeline;
    d = DataOutMainModule;
    @(posedge clk);
    #1;
    write = 1'b0;
    mMem[a] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    write = 1'b0;
    MemAddress = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    totalCnt++;
    if (StallPipeline !== 1'b0) $display("FAIL reset_stall: got %b want 0", StallPipeline);
    else passCnt++;
    totalCnt++;
    if (DataOutMainModule !== 16'h0000)
      $display("FAIL reset_data: got %h want 0000", DataOutMainModule);
    else passCnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_loads(input string name, input logic [15:0] addrs [$]);
    int stalls, es;
    logic [15:0] d, e;
    foreach (addrs[i]) begin
      es = expStall(addrs[i]);
      expQ.push_back(mMem[addrs[i]]);
      run_load(addrs[i], stalls, d);
      modelFill(addrs[i]);
      e = expQ.pop_front();
      totalCnt++;
      if (stalls !== es) $display("FAIL %s_stall[%h]: got %0d want %0d", name, addrs[i], stalls, es);
      else passCnt++;
      totalCnt++;
      if (d !== e) $display("FAIL %s_data[%h]: got %h want %h", name, addrs[i], d, e);
      else passCnt++;
    end
  endtask

  task automatic test_store(input string name, input logic [15:0] a, input logic [15:0] v);
    logic st;
    logic [15:0] d;
    run_store(a, v, st, d);
    totalCnt++;
    if (st !== 1'b0) $display("FAIL %s_stall[%h]: got %b want 0", name, a, st);
    else passCnt++;
    totalCnt++;
    if (d !== 16'h0000) $display("FAIL %s_data[%h]: got %h want 0000", name, a, d);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    test_store("b2b_st", 16'h0102, 16'h1234);
    test_loads("b2b_ld", '{16'h0102});
    test_store("b2b_st", 16'h0103, 16'h5678);
    test_loads("b2b_ld", '{16'h0103, 16'h0102});
  endtask

  task automatic test_reset_abort();
    test_store("abort_st", 16'h0500, 16'hCAFE);
    test_loads("abort_pre", '{16'h0010});
    write = 1'b0;
    MemAddress = 16'h0500;
    @(negedge clk);
    totalCnt++;
    if (StallPipeline !== 1'b1) $display("FAIL abort_miss_stall: got %b want 1", StallPipeline);
    else passCnt++;
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    totalCnt++;
    if (StallPipeline !== 1'b0) $display("FAIL abort_rst_stall: got %b want 0", StallPipeline);
    else passCnt++;
    totalCnt++;
    if (DataOutMainModule !== 16'h0000)
      $display("FAIL abort_rst_data: got %h want 0000", DataOutMainModule);
    else passCnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    test_loads("abort_post", '{16'h0500, 16'h0010});
  endtask

  task automatic test_addr_change();
    int stalls;
    logic [15:0] d, e;
    test_store("chg_st", 16'h0200, 16'h1111);
    test_store("chg_st", 16'h0304, 16'h2222);
    write = 1'b0;
    MemAddress = 16'h0200;
    stalls = 0;
    @(negedge clk);
    while (StallPipeline && stalls < 50) begin
      stalls++;
      if (stalls == 2) begin
        MemAddress = 16'h0304;
        expQ.push_back(mMem[16'h0304]);
      end
      @(negedge clk);
    end
    d = DataOutMainModule;
    @(posedge clk);
    #1;
    modelFill(16'h0200);
    modelFill(16'h0304);
    totalCnt++;
    if (stalls !== 2 * MissStall) $display("FAIL chg_stall: got %0d want %0d", stalls, 2 * MissStall);
    else passCnt++;
    totalCnt++;
    if (expQ.size() == 0) begin
      $display("FAIL chg_data: got no expectation queued want 1 entry");
    end else begin
      e = expQ.pop_front();
      if (d !== e) $display("FAIL chg_data: got %h want %h", d, e);
      else passCnt++;
    end
    test_loads("chg_old", '{16'h0200});
  endtask

  initial begin
    rst = 1'b1;
    write = 1'b0;
    DataIn = '0;
    MemAddress = '0;
    for (int i = 0; i < 65536; i++) mMem[i] = 16'h0000;
    modelReset();

    test_reset();
    test_loads("cold", '{16'h0000});
    test_store("store_hit", 16'h0001, 16'h0055);
    test_loads("load_hit", '{16'h0001});
    test_loads("conflict", '{16'h0041, 16'h0001});
    test_store("store_miss", 16'h0100, 16'hBEEF);
    test_loads("store_miss_ld", '{16'h0001, 16'h0100, 16'h0101, 16'h0102, 16'h0103});
    test_back_to_back();
    test_reset_abort();
    test_addr_change();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
